// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage that owns the PC and holds the IF/ID pipeline register.
//   It fetches over a req/ack handshake with a variable-latency instruction memory.
//   It honours the hazard freeze and the EXE branch redirect.
// Ports:
//   clk, rst (async, active-low)
//   freeze                     hold the PC and the IF/ID outputs
//   branch_taken, branch_addr  redirect the PC and flush IF/ID
//   imem_req, imem_addr        fetch request and its address
//   imem_ack, imem_rdata       fetch response
//   pc_out, instr_out          IF/ID contents presented to decode
//   valid_out                  IF/ID contents presented to decode
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc, req_addr, hold_buf, next_addr;

    // The request is decoded from the registered state, so an async reset drops it at once.
    // The address always comes from req_addr, which keeps it stable until the ack.
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = req_addr;
    assign next_addr = req_addr + PC_STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            hold_buf  <= '0;
            pc_out    <= '0;
            instr_out <= '0;
            valid_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_addr <= pc;
                    state    <= FETCH;
                end
                FETCH: begin
                    if (branch_taken) begin
                        pc        <= branch_addr;
                        instr_out <= '0;
                        valid_out <= 1'b0;
                        // An ack arriving with the branch carries wrong-path data, so it is dropped.
                        // Otherwise the in-flight request must still be drained.
                        if (imem_ack) req_addr <= branch_addr;
                        else state <= DRAIN;
                    end else if (imem_ack && !freeze) begin
                        pc_out    <= next_addr;
                        instr_out <= imem_rdata;
                        valid_out <= 1'b1;
                        pc        <= next_addr;
                        req_addr  <= next_addr;
                    end else if (imem_ack) begin
                        hold_buf <= imem_rdata;
                        state    <= HOLD;
                    end else if (!freeze) begin
                        instr_out <= '0;
                        valid_out <= 1'b0;
                    end
                end
                DRAIN: begin
                    instr_out <= '0;
                    valid_out <= 1'b0;
                    if (branch_taken) pc <= branch_addr;
                    // A branch that coincides with the ack also supplies the newest target.
                    if (imem_ack) begin
                        req_addr <= branch_taken ? branch_addr : pc;
                        state    <= FETCH;
                    end
                end
                default: begin
                    if (branch_taken) begin
                        pc        <= branch_addr;
                        req_addr  <= branch_addr;
                        instr_out <= '0;
                        valid_out <= 1'b0;
                        state     <= FETCH;
                    end else if (!freeze) begin
                        pc_out    <= next_addr;
                        instr_out <= hold_buf;
                        valid_out <= 1'b1;
                        pc        <= next_addr;
                        req_addr  <= next_addr;
                        state     <= FETCH;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed self-checking bench for if_fetch_stage.
//   The memory returns {16'hC0DE, addr[15:0]}.
//   Its ack is either tied to imem_req (zero-wait) or driven by hand.
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req, imem_ack, valid_out;
    logic [31:0] imem_addr, imem_rdata, pc_out, instr_out;
    logic        auto_ack = 1'b1;
    logic        ack_m = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
        .instr_out(instr_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;
    assign imem_ack   = auto_ack ? imem_req : ack_m;
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ifid(input string tag, input logic [31:0] p, input logic [31:0] i, input logic v);
        chk({tag, ".pc"}, pc_out, p);
        chk({tag, ".instr"}, instr_out, i);
        chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
    endtask

    task automatic req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, r});
        chk({tag, ".addr"}, imem_addr, a);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(); step();
        ifid("reset", 0, 0, 0);
        req("reset", 0, 0);
        rst = 1'b1;
        step();
        req("idle_exit", 1, 0);
        chk("idle_exit.valid", {31'd0, valid_out}, 0);
        step();
        ifid("zw0", 32'h4, 32'hC0DE_0000, 1);
        req("zw0", 1, 32'h4);
        step();
        ifid("zw1", 32'h8, 32'hC0DE_0004, 1);
        step();
        ifid("zw2", 32'hC, 32'hC0DE_0008, 1);
        req("zw2", 1, 32'hC);
        auto_ack = 1'b0;
        step();
        chk("wait.instr", instr_out, 0);
        chk("wait.valid", {31'd0, valid_out}, 0);
        req("wait", 1, 32'hC);
        ack_m = 1'b1;
        step();
        ifid("lat", 32'h10, 32'hC0DE_000C, 1);
        req("lat", 1, 32'h10);
        freeze = 1'b1;
        step();
        ack_m = 1'b0;
        ifid("frz0", 32'h10, 32'hC0DE_000C, 1);
        req("frz0", 0, 32'h10);
        step();
        ifid("frz1", 32'h10, 32'hC0DE_000C, 1);
        step();
        ifid("frz2", 32'h10, 32'hC0DE_000C, 1);
        freeze = 1'b0;
        step();
        ifid("unfrz", 32'h14, 32'hC0DE_0010, 1);
        req("unfrz", 1, 32'h14);
        auto_ack = 1'b1;
        step(); step(); step();
        ifid("run", 32'h20, 32'hC0DE_001C, 1);
        auto_ack = 1'b0;
        step();
        req("pend20", 1, 32'h20);
        chk("pend20.valid", {31'd0, valid_out}, 0);
        branch_taken = 1'b1;
        branch_addr = 32'h100;
        step();
        branch_taken = 1'b0;
        req("drain0", 1, 32'h20);
        chk("drain0.valid", {31'd0, valid_out}, 0);
        step();
        req("drain1", 1, 32'h20);
        ack_m = 1'b1;
        step();
        ack_m = 1'b0;
        ifid("drained", 32'h20, 0, 0);
        req("drained", 1, 32'h100);
        ack_m = 1'b1;
        step();
        ack_m = 1'b0;
        ifid("tgt", 32'h104, 32'hC0DE_0100, 1);
        branch_taken = 1'b1;
        branch_addr = 32'h200;
        freeze = 1'b1;
        ack_m = 1'b1;
        step();
        branch_taken = 1'b0;
        freeze = 1'b0;
        chk("brfrz.valid", {31'd0, valid_out}, 0);
        chk("brfrz.instr", instr_out, 0);
        req("brfrz", 1, 32'h200);
        step();
        ack_m = 1'b0;
        ifid("brfrz_tgt", 32'h204, 32'hC0DE_0200, 1);
        branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        ack_m = 1'b1;
        step();
        req("wrap_fetch", 1, 32'hFFFF_FFFC);
        step();
        ack_m = 1'b0;
        ifid("wrap", 32'h0, 32'hC0DE_FFFC, 1);
        req("wrap", 1, 32'h0);
        step();
        #2 rst = 1'b0;
        #1;
        ifid("midrst", 0, 0, 0);
        req("midrst", 0, 0);
        ack_m = 1'b1;
        step();
        ifid("lateack", 0, 0, 0);
        rst = 1'b1;
        ack_m = 1'b0;
        auto_ack = 1'b1;
        step();
        req("restart", 1, 0);
        chk("restart.valid", {31'd0, valid_out}, 0);
        step();
        ifid("restart0", 32'h4, 32'hC0DE_0000, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
